// File: rtl/rf_read_sequencer.sv
// rf_read_sequencer: read-side controller for a 16 x 16-bit register file.
//
// Accepts a two-operand read request, drives one-hot read enables onto the two
// shared bitline ports for SETTLE cycles, then captures both bitlines (with
// bypass of a write landing on the capture edge) and holds the result until
// the consumer takes it.
//
// Ports:
//   clk_i                     system clock, rising edge
//   rst_ni                    asynchronous active-low reset
//   req_valid_i / req_ready_o request handshake
//   src1_i, src2_i            register indices for ports 1 and 2
//   ren1_o, ren2_o            one-hot read enables (registered)
//   bitline1_i, bitline2_i    shared read bitlines
//   wr_en_i, wr_reg_i, wr_data_i  snooped register-file write port
//   rd_valid_o / rd_ready_i   result handshake
//   rd_data1_o, rd_data2_o    captured operand values
module rf_read_sequencer #(
    parameter int unsigned SETTLE      = 1,
    parameter int unsigned ZERO_REG_EN = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [3:0]  src1_i,
    input  logic [3:0]  src2_i,
    output logic [15:0] ren1_o,
    output logic [15:0] ren2_o,
    input  logic [15:0] bitline1_i,
    input  logic [15:0] bitline2_i,
    input  logic        wr_en_i,
    input  logic [3:0]  wr_reg_i,
    input  logic [15:0] wr_data_i,
    output logic        rd_valid_o,
    input  logic        rd_ready_i,
    output logic [15:0] rd_data1_o,
    output logic [15:0] rd_data2_o
);

    typedef enum logic [1:0] {StIdle, StDrive, StHold} state_e;

    localparam logic [3:0] SettleInit = 4'(SETTLE - 1);

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [3:0]  src1_q, src1_d;
    logic [3:0]  src2_q, src2_d;
    logic [15:0] ren1_q, ren1_d;
    logic [15:0] ren2_q, ren2_d;
    logic [15:0] data1_q, data1_d;
    logic [15:0] data2_q, data2_d;

    // Register 0 is hardwired to zero when enabled and must never drive a bitline.
    function automatic logic is_zero_reg(input logic [3:0] idx);
        return (ZERO_REG_EN != 0) && (idx == 4'd0);
    endfunction

    function automatic logic [15:0] en_mask(input logic [3:0] idx);
        if (is_zero_reg(idx)) return 16'h0000;
        return 16'h0001 << idx;
    endfunction

    // The array commits a write on the capture edge itself, so the bitline still
    // carries the old value; forward the write data instead.
    function automatic logic [15:0] capture(input logic [3:0]  idx,
                                            input logic [15:0] bl);
        if (is_zero_reg(idx)) return 16'h0000;
        if (wr_en_i && (wr_reg_i == idx)) return wr_data_i;
        return bl;
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        src1_d  = src1_q;
        src2_d  = src2_q;
        ren1_d  = ren1_q;
        ren2_d  = ren2_q;
        data1_d = data1_q;
        data2_d = data2_q;
        unique case (state_q)
            StIdle: begin
                if (req_valid_i) begin
                    src1_d  = src1_i;
                    src2_d  = src2_i;
                    cnt_d   = SettleInit;
                    ren1_d  = en_mask(src1_i);
                    ren2_d  = en_mask(src2_i);
                    state_d = StDrive;
                end
            end
            StDrive: begin
                if (cnt_q == 4'd0) begin
                    data1_d = capture(src1_q, bitline1_i);
                    data2_d = capture(src2_q, bitline2_i);
                    ren1_d  = 16'h0000;
                    ren2_d  = 16'h0000;
                    state_d = StHold;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            StHold: begin
                if (rd_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            src1_q  <= 4'd0;
            src2_q  <= 4'd0;
            ren1_q  <= 16'h0000;
            ren2_q  <= 16'h0000;
            data1_q <= 16'h0000;
            data2_q <= 16'h0000;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            src1_q  <= src1_d;
            src2_q  <= src2_d;
            ren1_q  <= ren1_d;
            ren2_q  <= ren2_d;
            data1_q <= data1_d;
            data2_q <= data2_d;
        end
    end

    assign req_ready_o = (state_q == StIdle);
    assign rd_valid_o  = (state_q == StHold);
    assign ren1_o      = ren1_q;
    assign ren2_o      = ren2_q;
    assign rd_data1_o  = data1_q;
    assign rd_data2_o  = data2_q;

endmodule

// File: tb/tb_rf_read_sequencer.sv
// Directed bench for rf_read_sequencer: three instances (SETTLE=1 with zero
// register, SETTLE=1 without zero register, SETTLE=3) share a behavioural
// register array that drives the bitlines from each instance's read enables.
module tb_rf_read_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  src1 = '0, src2 = '0;
    logic        wr_en = 1'b0;
    logic [3:0]  wr_reg = '0;
    logic [15:0] wr_data = '0;
    logic        bl_force = 1'b0;
    logic [15:0] bl_force_val = '0;
    logic [15:0] mem [16];

    // Per-instance handshake and outputs: a = main, n = no zero reg, s = SETTLE=3
    logic        req_a = 0, req_n = 0, req_s = 0;
    logic        rdy_a = 0, rdy_n = 0, rdy_s = 0;
    logic        rr_a, rr_n, rr_s, rv_a, rv_n, rv_s;
    logic [15:0] r1_a, r2_a, r1_n, r2_n, r1_s, r2_s;
    logic [15:0] b1_a, b2_a, b1_n, b2_n, b1_s, b2_s;
    logic [15:0] d1_a, d2_a, d1_n, d2_n, d1_s, d2_s;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    function automatic logic [15:0] bitline(input logic [15:0] ren, input logic [15:0] m [16],
                                            input logic f, input logic [15:0] fv);
        logic [15:0] r;
        if (f) return fv;
        if (ren == 16'h0000) return 16'hzzzz;
        r = '0;
        for (int i = 0; i < 16; i++) if (ren[i]) r = r | m[i];
        return r;
    endfunction

    always_comb begin
        b1_a = bitline(r1_a, mem, bl_force, bl_force_val);
        b2_a = bitline(r2_a, mem, bl_force, bl_force_val);
        b1_n = bitline(r1_n, mem, bl_force, bl_force_val);
        b2_n = bitline(r2_n, mem, bl_force, bl_force_val);
        b1_s = bitline(r1_s, mem, bl_force, bl_force_val);
        b2_s = bitline(r2_s, mem, bl_force, bl_force_val);
    end

    always @(posedge clk) if (wr_en) mem[wr_reg] <= wr_data;

    rf_read_sequencer #(.SETTLE(1), .ZERO_REG_EN(1)) u_dut_a (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_a), .req_ready_o(rr_a),
        .src1_i(src1), .src2_i(src2), .ren1_o(r1_a), .ren2_o(r2_a),
        .bitline1_i(b1_a), .bitline2_i(b2_a), .wr_en_i(wr_en), .wr_reg_i(wr_reg),
        .wr_data_i(wr_data), .rd_valid_o(rv_a), .rd_ready_i(rdy_a),
        .rd_data1_o(d1_a), .rd_data2_o(d2_a)
    );

    rf_read_sequencer #(.SETTLE(1), .ZERO_REG_EN(0)) u_dut_n (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_n), .req_ready_o(rr_n),
        .src1_i(src1), .src2_i(src2), .ren1_o(r1_n), .ren2_o(r2_n),
        .bitline1_i(b1_n), .bitline2_i(b2_n), .wr_en_i(wr_en), .wr_reg_i(wr_reg),
        .wr_data_i(wr_data), .rd_valid_o(rv_n), .rd_ready_i(rdy_n),
        .rd_data1_o(d1_n), .rd_data2_o(d2_n)
    );

    rf_read_sequencer #(.SETTLE(3), .ZERO_REG_EN(1)) u_dut_s (
        .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_s), .req_ready_o(rr_s),
        .src1_i(src1), .src2_i(src2), .ren1_o(r1_s), .ren2_o(r2_s),
        .bitline1_i(b1_s), .bitline2_i(b2_s), .wr_en_i(wr_en), .wr_reg_i(wr_reg),
        .wr_data_i(wr_data), .rd_valid_o(rv_s), .rd_ready_i(rdy_s),
        .rd_data1_o(d1_s), .rd_data2_o(d2_s)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 16'h0000;
        mem[2] = 16'h2222;
        mem[3] = 16'hBEEF;
        mem[5] = 16'h0001;
        mem[7] = 16'h1234;

        // Reset values while held
        #12;
        check_eq("rst_ren1", 32'(r1_a), 32'h0);
        check_eq("rst_ren2", 32'(r2_a), 32'h0);
        check_eq("rst_rd_valid", 32'(rv_a), 32'h0);
        check_eq("rst_data", {d1_a, d2_a}, 32'h0);
        rst_n = 1'b1;
        tick();
        check_eq("rst_req_ready", 32'(rr_a), 32'h1);

        // Basic read, SETTLE=1
        src1 = 4'd3; src2 = 4'd7; req_a = 1;
        tick();
        req_a = 0;
        check_eq("basic_ren1", 32'(r1_a), 32'h0008);
        check_eq("basic_ren2", 32'(r2_a), 32'h0080);
        check_eq("basic_busy", {31'h0, rr_a}, 32'h0);
        check_eq("basic_nvalid", 32'(rv_a), 32'h0);
        tick();
        check_eq("basic_ren_off", {r1_a, r2_a}, 32'h0);
        check_eq("basic_valid", 32'(rv_a), 32'h1);
        check_eq("basic_data", {d1_a, d2_a}, 32'hBEEF_1234);
        rdy_a = 1;
        tick();
        rdy_a = 0;
        check_eq("basic_done", {30'h0, rv_a, rr_a}, 32'h1);

        // Bypass hit on the capture edge
        src1 = 4'd5; src2 = 4'd2; req_a = 1;
        tick();
        req_a = 0;
        wr_en = 1; wr_reg = 4'd5; wr_data = 16'hA5A5;
        tick();
        wr_en = 0;
        check_eq("bypass_hit", {d1_a, d2_a}, 32'hA5A5_2222);
        rdy_a = 1;
        tick();
        rdy_a = 0;
        // Restore R5 then repeat with a write to another register
        wr_en = 1; wr_reg = 4'd5; wr_data = 16'h0001;
        tick();
        wr_en = 0; req_a = 1;
        tick();
        req_a = 0;
        wr_en = 1; wr_reg = 4'd6; wr_data = 16'h7777;
        tick();
        wr_en = 0;
        check_eq("bypass_miss", {d1_a, d2_a}, 32'h0001_2222);
        rdy_a = 1;
        tick();
        rdy_a = 0;

        // Zero register, with and without ZERO_REG_EN
        bl_force = 1; bl_force_val = 16'hFFFF;
        src1 = 4'd0; src2 = 4'd0; req_a = 1; req_n = 1;
        tick();
        req_a = 0; req_n = 0;
        check_eq("zero_ren", {r1_a, r2_a}, 32'h0);
        check_eq("nozero_ren", {r1_n, r2_n}, 32'h0001_0001);
        tick();
        check_eq("zero_data", {d1_a, d2_a}, 32'h0);
        check_eq("nozero_data", {d1_n, d2_n}, 32'hFFFF_FFFF);
        rdy_a = 1; rdy_n = 1;
        tick();
        rdy_a = 0; rdy_n = 0; bl_force = 0;

        // Backpressure: held data ignores writes, new requests ignored
        src1 = 4'd3; src2 = 4'd7; req_a = 1;
        tick();
        req_a = 0;
        tick();
        for (int i = 0; i < 5; i++) begin
            src1 = 4'd2; req_a = 1;
            wr_en = 1; wr_reg = 4'd3; wr_data = 16'(i + 1);
            tick();
            check_eq("bp_data", {d1_a, d2_a}, 32'hBEEF_1234);
            check_eq("bp_state", {30'h0, rv_a, rr_a}, 32'h2);
        end
        wr_en = 0; rdy_a = 1;
        tick();
        rdy_a = 0;
        check_eq("bp_release", {30'h0, rv_a, rr_a}, 32'h1);
        check_eq("bp_no_accept", 32'(r1_a), 32'h0);
        tick();
        req_a = 0;
        check_eq("bp_accept_ren1", 32'(r1_a), 32'h0004);
        check_eq("bp_accept_busy", 32'(rr_a), 32'h0);
        tick();
        check_eq("bp_new_data", {d1_a, d2_a}, 32'h2222_1234);
        rdy_a = 1;
        tick();
        rdy_a = 0;

        // SETTLE=3: only the last-cycle bitline value is captured
        src1 = 4'd7; src2 = 4'd3; req_s = 1;
        tick();
        req_s = 0;
        check_eq("s3_ren_e0", {r1_s, r2_s}, 32'h0080_0008);
        tick();
        check_eq("s3_ren_e1", {r1_s, 15'h0, rv_s}, 32'h0080_0000);
        bl_force = 1; bl_force_val = 16'h1111;
        tick();
        check_eq("s3_ren_e2", {r1_s, 15'h0, rv_s}, 32'h0080_0000);
        bl_force_val = 16'h3333;
        tick();
        bl_force = 0;
        check_eq("s3_valid_e3", {r1_s, 15'h0, rv_s}, 32'h0000_0001);
        check_eq("s3_data", {d1_s, d2_s}, 32'h3333_3333);
        rdy_s = 1;
        tick();
        rdy_s = 0;

        // Asynchronous reset mid-DRIVE
        src1 = 4'd3; src2 = 4'd3; req_s = 1;
        tick();
        req_s = 0;
        check_eq("arst_pre_ren1", 32'(r1_s), 32'h0008);
        #2 rst_n = 0;
        #1;
        check_eq("arst_ren", {r1_s, r2_s}, 32'h0);
        check_eq("arst_valid", 32'(rv_s), 32'h0);
        check_eq("arst_data_s", {d1_s, d2_s}, 32'h0);
        check_eq("arst_data_a", {d1_a, d2_a}, 32'h0);
        rst_n = 1;
        #1;
        check_eq("arst_ready", 32'(rr_s), 32'h1);
        tick();
        check_eq("arst_dropped", {30'h0, rv_s, rr_s}, 32'h1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
